nec_prefetch: RTL
=================

Name: nec_prefetch

Overview:
- Producer side of the instruction prefetch queue. It fetches code bytes over the core's 16-bit bus and fills the 8-byte ring that the instruction decoder reads as ipq[pc[2:0]+ofs].
- Tracks its own fetch pointer. Occupancy is derived from the decoder's consumed pc.
- Flushes on branch (set_pc). Honours the decoder's block_prefetch hint.

Parameters:
- RESET_PC, 16'h0000, fetch pointer value loaded on reset.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ce_1  in  1  phase-1 clock enable
- ce_2  in  1  phase-2 clock enable
- pc  in  16  decoder's current consume pointer
- new_pc  in  16  branch target
- set_pc  in  1  flush the queue and restart fetch at new_pc
- block_prefetch  in  1  inhibit new bus requests
- ipq_len  out  4  valid bytes in the queue, 0..8
- ipq  out  8x8  ring storage; byte at address A lives in ipq[A[2:0]]
- fetch_pc  out  16  address of the next byte to fetch
- bus_req  out  1  fetch request, held until bus_done
- bus_addr  out  16  request address; odd address means a single high-byte fetch
- bus_done  in  1  request complete; bus_rdata valid this cycle
- bus_rdata  in  16  fetched word, little-endian

Behaviour:
- Clock and reset:
  - All state updates only on clk edges where (ce_1|ce_2) is true.
  - reset overrides everything regardless of ce.
- Reset values:
  - bus_req=0, bus_addr=0, fetch_pc=RESET_PC, all ipq bytes=0.
  - state=IDLE, so ipq_len=(RESET_PC-pc)[3:0] and is 0 when the decoder pc matches.
- ipq_len: combinational, (fetch_pc - pc)[3:0]. Values above 8 are illegal; the decoder never runs ahead of fetch_pc.
- Space rule:
  - word_ok = (fetch_pc[0]==0) && ipq_len<=6
  - byte_ok = (fetch_pc[0]==1) && ipq_len<=7
- FSM:
  - IDLE:
    - If set_pc: fetch_pc<=new_pc and stay in IDLE.
    - Else if !block_prefetch && (word_ok|byte_ok): bus_req<=1, bus_addr<=fetch_pc, go to REQ.
  - REQ (bus_req=1, bus_addr stable):
    - If bus_done && set_pc: discard data, fetch_pc<=new_pc, bus_req<=0, go to IDLE.
    - Else if bus_done:
      - even address: ipq[a]<=rdata[7:0], ipq[a+1]<=rdata[15:8], fetch_pc+=2.
      - odd address: ipq[a]<=rdata[15:8], fetch_pc+=1.
      - Then bus_req<=0 and go to IDLE.
    - Else if set_pc: fetch_pc<=new_pc, go to DISCARD. The bus cycle cannot be cancelled, so bus_req stays at 1.
  - DISCARD (bus_req=1):
    - set_pc again: update fetch_pc only.
    - bus_done: drop data, bus_req<=0, go to IDLE.
    - ipq_len is forced to 0 in this state.
- Latency and gaps:
  - Fetched bytes appear in ipq_len on the first enabled cycle after the bus_done edge.
  - At least one enabled IDLE cycle separates consecutive requests.
- block_prefetch only gates the IDLE->REQ transition. An in-flight request completes normally.
- Address arithmetic:
  - Ring index a = bus_addr[2:0]; a+1 wraps modulo 8.
  - fetch_pc wraps modulo 2^16 (0xFFFF+1 = 0x0000).
- The decoder consumes on the same edge a fetch completes. Both pointers update and the len equation stays consistent; no interlock is needed.

Test Plan:
- Reset with RESET_PC=0, pc=0 -> ipq_len=0, bus_req=0. On the first enabled cycle: bus_req=1, bus_addr=0x0000.
- set_pc new_pc=0x0100, then bus_done with rdata 0x3412, then later 0x7856 -> ipq[0..3]=12,34,56,78, ipq_len=4, fetch_pc=0x0104.
- Decoder pc held at 0x0100, keep completing words -> requests stop at ipq_len=8 with fetch_pc=0x0108. Advance pc by 1 (len=7, even address) -> still no request. Advance pc to 0x0102 -> request at 0x0108.
- set_pc 0x0203 -> bus_addr=0x0203; rdata 0xAB00 -> ipq[3]=0xAB, ipq_len=1, next bus_addr=0x0204.
- During REQ at 0x0110 assert set_pc new_pc=0x0400, bus_done two enabled cycles later with 0xFFFF -> ipq_len=0 throughout, data dropped, next bus_addr=0x0400. Repeat with set_pc coincident with bus_done -> same result, no DISCARD entry.
- block_prefetch=1 with len=2 -> no request issued; an in-flight request still completes. Separately, set_pc 0xFFFE, done 0x2211 -> fetch_pc=0x0000, ipq[6]=11, ipq[7]=22.

Source files
------------

// File: rtl/nec_prefetch.sv
// Prefetch producer: fills the 8-byte decoder ring from the 16-bit bus. Bytes count in ipq_len one enabled cycle after bus_done.
// Backpressure: no request while the ring lacks room or block_prefetch is high; bus_req is held until bus_done.
module nec_prefetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_1,
    input  logic             ce_2,
    input  logic [15:0]      pc,
    input  logic [15:0]      new_pc,
    input  logic             set_pc,
    input  logic             block_prefetch,
    output logic [3:0]       ipq_len,
    output logic [7:0][7:0]  ipq,
    output logic [15:0]      fetch_pc,
    output logic             bus_req,
    output logic [15:0]      bus_addr,
    input  logic             bus_done,
    input  logic [15:0]      bus_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    state_t          r_state;
    logic [15:0]     r_fetch_pc;
    logic [15:0]     r_bus_addr;
    logic            r_bus_req;
    logic [7:0][7:0] r_ipq;

    logic        w_ce;
    logic [15:0] w_dist;
    logic        w_space_ok;
    logic [2:0]  w_a;
    logic [2:0]  w_a1;

    assign w_ce   = ce_1 | ce_2;
    assign w_dist = r_fetch_pc - pc;
    // Legal distances are 0..8, so the full-width compare matches the 4-bit length rule.
    assign w_space_ok = r_fetch_pc[0] ? (w_dist <= 16'd7) : (w_dist <= 16'd6);
    assign w_a    = r_bus_addr[2:0];
    assign w_a1   = w_a + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_bus_addr <= 16'h0000;
            r_bus_req  <= 1'b0;
            r_ipq      <= '0;
        end else if (w_ce) begin
            case (r_state)
                S_IDLE: begin
                    if (set_pc) begin
                        r_fetch_pc <= new_pc;
                    end else if (!block_prefetch && w_space_ok) begin
                        r_bus_req  <= 1'b1;
                        r_bus_addr <= r_fetch_pc;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_done) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_IDLE;
                        if (set_pc) begin
                            r_fetch_pc <= new_pc;
                        end else if (r_bus_addr[0]) begin
                            r_ipq[w_a] <= bus_rdata[15:8];
                            r_fetch_pc <= r_bus_addr + 16'd1;
                        end else begin
                            r_ipq[w_a]  <= bus_rdata[7:0];
                            r_ipq[w_a1] <= bus_rdata[15:8];
                            r_fetch_pc  <= r_bus_addr + 16'd2;
                        end
                    end else if (set_pc) begin
                        // The bus cycle cannot be cancelled: keep bus_req and drop its data later.
                        r_fetch_pc <= new_pc;
                        r_state    <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (set_pc) begin
                        r_fetch_pc <= new_pc;
                    end
                    if (bus_done) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ipq_len  = (r_state == S_DISCARD) ? 4'd0 : w_dist[3:0];
    assign ipq      = r_ipq;
    assign fetch_pc = r_fetch_pc;
    assign bus_req  = r_bus_req;
    assign bus_addr = r_bus_addr;
endmodule
